// File: rtl/me_block_sequencer.sv
// me_block_sequencer
//
// Sequences one motion-estimation job per macroblock in front of the
// Me_engine. For each block it streams CUR_WORDS current-block words and
// REF_WORDS reference-window words into the engine memories, then pulses
// eng_go. It waits for eng_done, returns the captured motion vector on a
// valid/ready port, and holds the engine in reset for RST_CYCLES before
// the next block. This repeats num_blocks times per accepted start.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   start, num_blocks job start pulse and block count (latched)
//   range_r           search range (latched, driven on eng_r)
//   s_data/s_valid/s_ready            input word stream
//   eng_reset/eng_go/eng_r            engine control
//   eng_addr_cur/eng_data_cur/eng_we_cur  current-memory write port
//   eng_addr_ref/eng_data_ref/eng_we_ref  reference-memory write port
//   eng_done/eng_m_i/eng_m_j          engine completion and result
//   mv_valid/mv_ready/mv_i/mv_j/mv_block_idx  result port
//   busy              high whenever not idle
//   timeout_err       sticky engine timeout flag

module me_block_sequencer #(
    parameter int CUR_WORDS      = 32,
    parameter int REF_WORDS      = 128,
    parameter int RST_CYCLES     = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] num_blocks,
    input  logic [1:0]  range_r,
    input  logic [63:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        eng_reset,
    output logic        eng_go,
    output logic [1:0]  eng_r,
    output logic [4:0]  eng_addr_cur,
    output logic [63:0] eng_data_cur,
    output logic        eng_we_cur,
    output logic [6:0]  eng_addr_ref,
    output logic [63:0] eng_data_ref,
    output logic        eng_we_ref,
    input  logic        eng_done,
    input  logic [7:0]  eng_m_i,
    input  logic [7:0]  eng_m_j,
    output logic        mv_valid,
    input  logic        mv_ready,
    output logic [7:0]  mv_i,
    output logic [7:0]  mv_j,
    output logic [15:0] mv_block_idx,
    output logic        busy,
    output logic        timeout_err
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RST_W = $clog2(RST_CYCLES + 1);

    localparam logic [6:0]       CUR_LAST = 7'(CUR_WORDS - 1);
    localparam logic [6:0]       REF_LAST = 7'(REF_WORDS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [RST_W-1:0] RST_ONE  = RST_W'(1);

    typedef enum logic [2:0] {
        IDLE, LOAD_CUR, LOAD_REF, GO, WAIT_DONE, RESULT, ENG_RST
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  word_cnt_q, word_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [15:0] blk_idx_q, blk_idx_d;
    logic [15:0] num_blocks_q, num_blocks_d;
    logic [1:0]  range_q, range_d;
    logic        abort_q, abort_d;
    logic        timeout_err_q, timeout_err_d;
    logic        s_ready_q, s_ready_d;
    logic        eng_reset_q, eng_reset_d;
    logic        busy_q, busy_d;
    logic        eng_go_q, eng_go_d;
    logic        we_cur_q, we_cur_d;
    logic [4:0]  addr_cur_q, addr_cur_d;
    logic [63:0] data_cur_q, data_cur_d;
    logic        we_ref_q, we_ref_d;
    logic [6:0]  addr_ref_q, addr_ref_d;
    logic [63:0] data_ref_q, data_ref_d;
    logic        mv_valid_q, mv_valid_d;
    logic [7:0]  mv_i_q, mv_i_d;
    logic [7:0]  mv_j_q, mv_j_d;
    logic [15:0] mv_idx_q, mv_idx_d;
    logic        hs;

    // s_ready_q is the port value, so a handshake is exactly what the
    // upstream producer observes.
    assign hs = s_valid && s_ready_q;

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        to_cnt_d      = to_cnt_q;
        rst_cnt_d     = rst_cnt_q;
        blk_idx_d     = blk_idx_q;
        num_blocks_d  = num_blocks_q;
        range_d       = range_q;
        abort_d       = abort_q;
        timeout_err_d = timeout_err_q;
        eng_go_d      = 1'b0;
        we_cur_d      = 1'b0;
        addr_cur_d    = addr_cur_q;
        data_cur_d    = data_cur_q;
        we_ref_d      = 1'b0;
        addr_ref_d    = addr_ref_q;
        data_ref_d    = data_ref_q;
        mv_valid_d    = mv_valid_q;
        mv_i_d        = mv_i_q;
        mv_j_d        = mv_j_q;
        mv_idx_d      = mv_idx_q;

        case (state_q)
            IDLE: begin
                if (start && (num_blocks != 16'd0)) begin
                    num_blocks_d  = num_blocks;
                    range_d       = range_r;
                    timeout_err_d = 1'b0;
                    abort_d       = 1'b0;
                    blk_idx_d     = 16'd0;
                    word_cnt_d    = 7'd0;
                    state_d       = LOAD_CUR;
                end
            end
            LOAD_CUR: begin
                if (hs) begin
                    we_cur_d   = 1'b1;
                    addr_cur_d = word_cnt_q[4:0];
                    data_cur_d = s_data;
                    if (word_cnt_q == CUR_LAST) begin
                        word_cnt_d = 7'd0;
                        state_d    = LOAD_REF;
                    end else begin
                        word_cnt_d = word_cnt_q + 7'd1;
                    end
                end
            end
            LOAD_REF: begin
                if (hs) begin
                    we_ref_d   = 1'b1;
                    addr_ref_d = word_cnt_q;
                    data_ref_d = s_data;
                    if (word_cnt_q == REF_LAST) begin
                        word_cnt_d = 7'd0;
                        state_d    = GO;
                    end else begin
                        word_cnt_d = word_cnt_q + 7'd1;
                    end
                end
            end
            GO: begin
                // GO coincides with the final ref write, so eng_go lands
                // one cycle after the reference memory is complete.
                eng_go_d = 1'b1;
                to_cnt_d = '0;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A done level left over from the go cycle is not trusted.
                if (eng_done && !eng_go_q) begin
                    mv_i_d     = eng_m_i;
                    mv_j_d     = eng_m_j;
                    mv_idx_d   = blk_idx_q;
                    mv_valid_d = 1'b1;
                    state_d    = RESULT;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    abort_d       = 1'b1;
                    blk_idx_d     = blk_idx_q + 16'd1;
                    rst_cnt_d     = '0;
                    state_d       = ENG_RST;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end
            RESULT: begin
                if (mv_ready) begin
                    mv_valid_d = 1'b0;
                    blk_idx_d  = blk_idx_q + 16'd1;
                    rst_cnt_d  = '0;
                    state_d    = ENG_RST;
                end
            end
            ENG_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    word_cnt_d = 7'd0;
                    if (abort_q || (blk_idx_q == num_blocks_q)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD_CUR;
                    end
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Level outputs are registered from the next state so they change
        // on the same edge as the state register.
        eng_reset_d = (state_d == IDLE) || (state_d == ENG_RST);
        s_ready_d   = (state_d == LOAD_CUR) || (state_d == LOAD_REF);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            word_cnt_q    <= 7'd0;
            to_cnt_q      <= '0;
            rst_cnt_q     <= '0;
            blk_idx_q     <= 16'd0;
            num_blocks_q  <= 16'd0;
            range_q       <= 2'd0;
            abort_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            s_ready_q     <= 1'b0;
            eng_reset_q   <= 1'b1;
            busy_q        <= 1'b0;
            eng_go_q      <= 1'b0;
            we_cur_q      <= 1'b0;
            addr_cur_q    <= 5'd0;
            data_cur_q    <= 64'd0;
            we_ref_q      <= 1'b0;
            addr_ref_q    <= 7'd0;
            data_ref_q    <= 64'd0;
            mv_valid_q    <= 1'b0;
            mv_i_q        <= 8'd0;
            mv_j_q        <= 8'd0;
            mv_idx_q      <= 16'd0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            to_cnt_q      <= to_cnt_d;
            rst_cnt_q     <= rst_cnt_d;
            blk_idx_q     <= blk_idx_d;
            num_blocks_q  <= num_blocks_d;
            range_q       <= range_d;
            abort_q       <= abort_d;
            timeout_err_q <= timeout_err_d;
            s_ready_q     <= s_ready_d;
            eng_reset_q   <= eng_reset_d;
            busy_q        <= busy_d;
            eng_go_q      <= eng_go_d;
            we_cur_q      <= we_cur_d;
            addr_cur_q    <= addr_cur_d;
            data_cur_q    <= data_cur_d;
            we_ref_q      <= we_ref_d;
            addr_ref_q    <= addr_ref_d;
            data_ref_q    <= data_ref_d;
            mv_valid_q    <= mv_valid_d;
            mv_i_q        <= mv_i_d;
            mv_j_q        <= mv_j_d;
            mv_idx_q      <= mv_idx_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign eng_reset    = eng_reset_q;
    assign eng_go       = eng_go_q;
    assign eng_r        = range_q;
    assign eng_we_cur   = we_cur_q;
    assign eng_addr_cur = addr_cur_q;
    assign eng_data_cur = data_cur_q;
    assign eng_we_ref   = we_ref_q;
    assign eng_addr_ref = addr_ref_q;
    assign eng_data_ref = data_ref_q;
    assign mv_valid     = mv_valid_q;
    assign mv_i         = mv_i_q;
    assign mv_j         = mv_j_q;
    assign mv_block_idx = mv_idx_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_me_block_sequencer.sv
// tb_me_block_sequencer
//
// Directed bench for me_block_sequencer with a small behavioural engine
// that answers eng_go with eng_done three cycles later, using per-block
// motion vectors from a table. Stimulus changes and output sampling both
// happen on the falling clock edge.

module tb_me_block_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_blocks = 16'd0;
    logic [1:0]  range_r = 2'd0;
    logic [63:0] s_data = 64'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        eng_reset, eng_go;
    logic [1:0]  eng_r;
    logic [4:0]  eng_addr_cur;
    logic [63:0] eng_data_cur;
    logic        eng_we_cur;
    logic [6:0]  eng_addr_ref;
    logic [63:0] eng_data_ref;
    logic        eng_we_ref;
    logic        eng_done = 1'b0;
    logic [7:0]  eng_m_i = 8'd0;
    logic [7:0]  eng_m_j = 8'd0;
    logic        mv_valid;
    logic        mv_ready = 1'b0;
    logic [7:0]  mv_i, mv_j;
    logic [15:0] mv_block_idx;
    logic        busy, timeout_err;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] mi_tab [4];
    logic [7:0] mj_tab [4];
    int  go_count = 0;
    bit  engine_en = 1'b1;
    bit  eng_armed = 1'b0;
    int  eng_delay = 0;

    always #5 clk = ~clk;

    me_block_sequencer #(
        .CUR_WORDS(32), .REF_WORDS(128), .RST_CYCLES(3), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks),
        .range_r(range_r), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .eng_reset(eng_reset), .eng_go(eng_go), .eng_r(eng_r),
        .eng_addr_cur(eng_addr_cur), .eng_data_cur(eng_data_cur), .eng_we_cur(eng_we_cur),
        .eng_addr_ref(eng_addr_ref), .eng_data_ref(eng_data_ref), .eng_we_ref(eng_we_ref),
        .eng_done(eng_done), .eng_m_i(eng_m_i), .eng_m_j(eng_m_j),
        .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_i(mv_i), .mv_j(mv_j),
        .mv_block_idx(mv_block_idx), .busy(busy), .timeout_err(timeout_err)
    );

    // Behavioural engine: done follows go by three cycles, cleared by reset.
    always @(negedge clk) begin
        if (eng_reset) begin
            eng_done  = 1'b0;
            eng_armed = 1'b0;
        end else if (eng_go) begin
            eng_armed = engine_en;
            eng_delay = 0;
        end else if (eng_armed && !eng_done) begin
            eng_delay++;
            if (eng_delay == 3) begin
                eng_done = 1'b1;
                eng_m_i  = mi_tab[go_count % 4];
                eng_m_j  = mj_tab[go_count % 4];
                go_count++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] word_of(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {8{b}};
    endfunction

    task automatic start_job(input logic [15:0] n, input logic [1:0] r);
        start = 1'b1;
        num_blocks = n;
        range_r = r;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams one full block and checks every write-port cycle, then the go pulse.
    task automatic load_block(input bit toggle, input bit poke, input logic [1:0] exp_r);
        int sent = 0;
        int cyc = 0;
        int pend_k = 0;
        bit pend = 1'b0;
        bit poked = 1'b0;
        while ((sent < 160 || pend) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            tests_run++;
            if (pend && pend_k < 32) begin
                if ({eng_we_cur, eng_we_ref, eng_addr_cur, eng_data_cur} !==
                    {2'b10, 5'(pend_k), word_of(pend_k)}) begin
                    tests_failed++;
                    $display("[TB] FAIL cur_write k=%0d: got we=%b/%b addr=%0d data=%h, expected we=1/0 addr=%0d data=%h",
                             pend_k, eng_we_cur, eng_we_ref, eng_addr_cur, eng_data_cur, pend_k, word_of(pend_k));
                end
            end else if (pend) begin
                if ({eng_we_cur, eng_we_ref, eng_addr_ref, eng_data_ref} !==
                    {2'b01, 7'(pend_k - 32), word_of(pend_k)}) begin
                    tests_failed++;
                    $display("[TB] FAIL ref_write k=%0d: got we=%b/%b addr=%0d data=%h, expected we=0/1 addr=%0d data=%h",
                             pend_k, eng_we_cur, eng_we_ref, eng_addr_ref, eng_data_ref, pend_k - 32, word_of(pend_k));
                end
            end else begin
                if ({eng_we_cur, eng_we_ref} !== 2'b00) begin
                    tests_failed++;
                    $display("[TB] FAIL no_write cyc=%0d: got we=%b/%b, expected 0/0", cyc, eng_we_cur, eng_we_ref);
                end
            end
            pend = 1'b0;
            if (sent < 160) begin
                s_valid = toggle ? cyc[0] : 1'b1;
                s_data  = word_of(sent);
                if (s_valid && s_ready) begin
                    pend = 1'b1;
                    pend_k = sent;
                    sent++;
                end
            end else begin
                s_valid = 1'b0;
            end
            if (poke && !poked && sent == 10) begin
                poked = 1'b1;
                start = 1'b1;
                num_blocks = 16'd7;
                range_r = 2'd1;
            end
        end
        s_valid = 1'b0;
        start = 1'b0;
        tests_run++;
        if (cyc >= 2000) begin
            tests_failed++;
            $display("[TB] FAIL load_timeout: got %0d words accepted, expected 160", sent);
        end
        tests_run++;
        if (eng_r !== exp_r) begin
            tests_failed++;
            $display("[TB] FAIL eng_r: got %0d, expected %0d", eng_r, exp_r);
        end
        @(negedge clk);
        tests_run++;
        if ({eng_go, s_ready, eng_we_ref} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL go_pulse: got go=%b s_ready=%b we_ref=%b, expected 1/0/0", eng_go, s_ready, eng_we_ref);
        end
        @(negedge clk);
        tests_run++;
        if ({eng_go, s_ready} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL go_single: got go=%b s_ready=%b, expected 0/0", eng_go, s_ready);
        end
    endtask

    // Waits for a result, holds it for 'delay' cycles, then checks the engine reset window.
    task automatic wait_result(input logic [7:0] ei, input logic [7:0] ej,
                               input logic [15:0] eidx, input int delay, input bit last);
        int cyc = 0;
        while (mv_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (cyc >= 200) begin
            tests_failed++;
            $display("[TB] FAIL mv_wait: got no mv_valid in %0d cycles, expected one", cyc);
        end
        for (int i = 0; i <= delay; i++) begin
            tests_run++;
            if ({mv_valid, mv_i, mv_j, mv_block_idx, eng_reset} !== {1'b1, ei, ej, eidx, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL mv_hold i=%0d: got v=%b i=%h j=%h idx=%0d er=%b, expected v=1 i=%h j=%h idx=%0d er=0",
                         i, mv_valid, mv_i, mv_j, mv_block_idx, eng_reset, ei, ej, eidx);
            end
            if (i == delay) mv_ready = 1'b1;
            @(negedge clk);
        end
        mv_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if ({mv_valid, eng_reset, busy} !== 3'b011) begin
                tests_failed++;
                $display("[TB] FAIL eng_rst k=%0d: got v=%b er=%b busy=%b, expected 0/1/1", k, mv_valid, eng_reset, busy);
            end
            @(negedge clk);
        end
        tests_run++;
        if ({busy, eng_reset, s_ready} !== (last ? 3'b010 : 3'b101)) begin
            tests_failed++;
            $display("[TB] FAIL after_rst: got busy=%b er=%b s_ready=%b, expected %b",
                     busy, eng_reset, s_ready, (last ? 3'b010 : 3'b101));
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({eng_reset, s_ready, eng_go, eng_we_cur, eng_we_ref, eng_addr_cur, eng_addr_ref,
             eng_data_cur, eng_data_ref, eng_r, mv_valid, mv_i, mv_j, mv_block_idx, busy, timeout_err}
            !== {1'b1, 181'd0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got er=%b rdy=%b go=%b busy=%b terr=%b mvv=%b, expected er=1 rest 0",
                     eng_reset, s_ready, eng_go, busy, timeout_err, mv_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, eng_reset, s_ready} !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_reset: got busy=%b er=%b rdy=%b, expected 0/1/0", busy, eng_reset, s_ready);
        end
    endtask

    task automatic test_zero_blocks;
        start_job(16'd0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({busy, s_ready, eng_reset} !== 3'b001) begin
                tests_failed++;
                $display("[TB] FAIL zero_blocks i=%0d: got busy=%b rdy=%b er=%b, expected 0/0/1", i, busy, s_ready, eng_reset);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_block;
        go_count = 0;
        engine_en = 1'b1;
        mi_tab[0] = 8'h03; mj_tab[0] = 8'hFE;
        start_job(16'd1, 2'd2);
        load_block(1'b0, 1'b0, 2'd2);
        wait_result(8'h03, 8'hFE, 16'd0, 5, 1'b1);
    endtask

    task automatic test_multi_block;
        int delays [3] = '{0, 2, 1};
        go_count = 0;
        engine_en = 1'b1;
        mi_tab[0] = 8'h01; mj_tab[0] = 8'h01;
        mi_tab[1] = 8'h00; mj_tab[1] = 8'h00;
        mi_tab[2] = 8'hFF; mj_tab[2] = 8'h02;
        start_job(16'd3, 2'd3);
        for (int b = 0; b < 3; b++) begin
            load_block(1'b1, (b == 0), 2'd3);
            wait_result(mi_tab[b], mj_tab[b], 16'(b), delays[b], (b == 2));
        end
    endtask

    task automatic test_timeout;
        go_count = 0;
        engine_en = 1'b0;
        start_job(16'd2, 2'd1);
        load_block(1'b0, 1'b0, 2'd1);
        for (int n = 2; n <= 100; n++) begin
            tests_run++;
            if ({timeout_err, mv_valid, eng_reset, busy} !== 4'b0001) begin
                tests_failed++;
                $display("[TB] FAIL wait_done n=%0d: got terr=%b mvv=%b er=%b busy=%b, expected 0/0/0/1",
                         n, timeout_err, mv_valid, eng_reset, busy);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if ({timeout_err, mv_valid, eng_reset, busy} !== 4'b1011) begin
                tests_failed++;
                $display("[TB] FAIL timeout_rst k=%0d: got terr=%b mvv=%b er=%b busy=%b, expected 1/0/1/1",
                         k, timeout_err, mv_valid, eng_reset, busy);
            end
            @(negedge clk);
        end
        tests_run++;
        if ({timeout_err, mv_valid, eng_reset, busy, s_ready} !== 5'b10100) begin
            tests_failed++;
            $display("[TB] FAIL timeout_idle: got terr=%b mvv=%b er=%b busy=%b rdy=%b, expected 1/0/1/0/0",
                     timeout_err, mv_valid, eng_reset, busy, s_ready);
        end
        engine_en = 1'b1;
    endtask

    task automatic test_reset_mid_load;
        int sent = 0;
        int cyc = 0;
        start_job(16'd1, 2'd0);
        tests_run++;
        if ({timeout_err, busy} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL start_clears_err: got terr=%b busy=%b, expected 0/1", timeout_err, busy);
        end
        while (sent < 50 && cyc < 500) begin
            s_valid = 1'b1;
            s_data  = word_of(sent);
            if (s_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        // Word 50 is offered as reset is asserted; it must not be written.
        s_data = word_of(50);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if ({busy, eng_reset, s_ready, eng_we_ref, eng_we_cur} !== 5'b01000) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid_load i=%0d: got busy=%b er=%b rdy=%b we_ref=%b we_cur=%b, expected 0/1/0/0/0",
                         i, busy, eng_reset, s_ready, eng_we_ref, eng_we_cur);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({busy, eng_reset, s_ready, eng_we_ref, mv_valid} !== 5'b01000) begin
                tests_failed++;
                $display("[TB] FAIL post_reset_idle i=%0d: got busy=%b er=%b rdy=%b we_ref=%b mvv=%b, expected 0/1/0/0/0",
                         i, busy, eng_reset, s_ready, eng_we_ref, mv_valid);
            end
        end
        s_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_blocks();
        test_single_block();
        test_multi_block();
        test_timeout();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/me_block_sequencer.md
Name: me_block_sequencer

Overview:
- Controller sitting in front of Me_engine; sequences one motion-estimation job per macroblock.
- Accepts a 64-bit word stream carrying the current block and the reference window, and writes it into the engine's current and reference memories.
- Pulses go, waits for done, captures the motion vector and returns it on a valid/ready result port.
- Re-initialises the engine between blocks. Repeats for num_blocks blocks per start.

Parameters:
- CUR_WORDS, 32: 64-bit words per current block (16x16 pixels, 2 words per row).
- REF_WORDS, 128: 64-bit words per reference window (32x32 pixels, 4 words per row).
- RST_CYCLES, 3: engine reset pulse length between blocks.
- TIMEOUT_CYCLES, 65535: maximum cycles in WAIT_DONE before abort.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low.
- start  in  1  pulse; begins a job when idle.
- num_blocks  in  16  blocks in the job; latched on start.
- range_r  in  2  search range; latched on start, driven to eng_r.
- s_data  in  64  stream word, pixel 0 in bits [7:0].
- s_valid  in  1  stream word valid.
- s_ready  out  1  sequencer accepts the word.
- eng_reset  out  1  active-high reset to engine.
- eng_go  out  1  one-cycle start pulse to engine.
- eng_r  out  2  search range to engine.
- eng_addr_cur  out  5  current-memory write address.
- eng_data_cur  out  64  current-memory write data.
- eng_we_cur  out  1  current-memory write enable.
- eng_addr_ref  out  7  reference-memory write address.
- eng_data_ref  out  64  reference-memory write data.
- eng_we_ref  out  1  reference-memory write enable.
- eng_done  in  1  engine finished.
- eng_m_i  in  8  engine vertical MV.
- eng_m_j  in  8  engine horizontal MV.
- mv_valid  out  1  result valid.
- mv_ready  in  1  result consumer ready.
- mv_i  out  8  captured vertical MV.
- mv_j  out  8  captured horizontal MV.
- mv_block_idx  out  16  index of block, 0-based within the job.
- busy  out  1  not in IDLE.
- timeout_err  out  1  sticky; cleared on accepted start.

Behaviour:
- Reset (reset==0 at clk edge): state IDLE.
  - eng_reset=1.
  - All other outputs 0: s_ready, eng_go, eng_we_*, eng_addr_*, eng_data_*, eng_r, mv_*, busy, timeout_err.
  - Counters cleared.
  - Reset mid-job aborts immediately; no mv_valid is produced for the aborted block.
- States: IDLE, LOAD_CUR, LOAD_REF, GO, WAIT_DONE, RESULT, ENG_RST.
- IDLE:
  - eng_reset=1, s_ready=0.
  - start=1 with num_blocks!=0: latch num_blocks and range_r, clear timeout_err and block index, go to LOAD_CUR.
  - start with num_blocks==0 is ignored. start outside IDLE is ignored.
- LOAD_CUR:
  - eng_reset=0, s_ready=1.
  - Each handshake (s_valid&&s_ready) on word k: next cycle eng_we_cur=1, eng_addr_cur=k, eng_data_cur=s_data. Registered, so exactly one cycle of latency.
  - After word CUR_WORDS-1 is accepted, go to LOAD_REF.
  - A stall (s_valid=0) gives eng_we_cur=0 that cycle.
- LOAD_REF: same as LOAD_CUR using eng_*_ref, k=0..REF_WORDS-1. After the last word is accepted, go to GO.
  - s_ready is held 0 from the cycle after the last ref word until the next LOAD_CUR.
- GO:
  - Entered on the cycle the last ref write is driven.
  - eng_go=1 in the following cycle, for exactly one cycle.
  - Then WAIT_DONE with the timeout counter cleared.
- WAIT_DONE:
  - The first cycle eng_done==1 captures eng_m_i/eng_m_j into mv_i/mv_j and the block index into mv_block_idx; mv_valid=1 next cycle; go to RESULT.
  - eng_done in the same cycle as eng_go is ignored.
  - If the counter reaches TIMEOUT_CYCLES first: set timeout_err, go to ENG_RST, mark the job aborted (return to IDLE after reset).
- RESULT:
  - mv_valid held high, mv_* held stable, until mv_ready==1.
  - The handshake cycle is the last mv_valid cycle; then go to ENG_RST.
- ENG_RST:
  - eng_reset=1 for exactly RST_CYCLES cycles.
  - Block index increments.
  - If index==num_blocks or the job was aborted, go to IDLE; else go to LOAD_CUR.
- busy=1 in every state except IDLE.
- eng_r is driven constantly from the latched range_r.
- Widths: the block index counter is 16 bits, and the word counter is 7 bits and wraps to 0 at each phase change.

Test Plan:
- Reset held low 2 cycles mid-LOAD_REF (word 50) -> next cycle IDLE, eng_reset=1, s_ready=0, no further eng_we_ref, busy=0.
- start, num_blocks=1, range_r=2, continuous stream of 160 words (word k = k replicated) -> 32 cur writes at addr 0..31 then 128 ref writes at addr 0..127, each 1 cycle after acceptance. eng_go is a single pulse 1 cycle after the ref write at addr 127. eng_r=2.
- Engine model asserts eng_done with m_i=3, m_j=0xFE; mv_ready held low 5 cycles -> mv_valid=1 stable with mv_i=3, mv_j=0xFE, mv_block_idx=0 until the ready cycle, then eng_reset high exactly 3 cycles, then IDLE.
- num_blocks=3, s_valid toggled 50%, per-block MVs (1,1),(0,0),(0xFF,2) -> three results with idx 0,1,2 in order. Writes occur only on handshake cycles with contiguous addresses. start pulsed mid-job has no effect.
- eng_done never asserted, TIMEOUT_CYCLES=100 -> timeout_err=1 after 100 WAIT_DONE cycles, no mv_valid, eng_reset 3 cycles, IDLE. The next start clears timeout_err.
- start with num_blocks=0 -> stays IDLE, busy=0, s_ready=0.
